// File: rtl/seg7_capture_if.sv
// Bus between the multiplexed seven-segment pins and the capture block:
// raw select/segment inputs plus the decoded readback and strobes.
interface seg7_capture_if;
  logic [7:0]  sel_in;
  logic [6:0]  seg_in;
  logic [31:0] digits_out;
  logic [7:0]  valid_out;
  logic        upd_pulse;
  logic [2:0]  upd_idx;
  logic        err_pulse;
  logic [7:0]  err_cnt;

  modport master (
    output sel_in,
    output seg_in,
    input  digits_out,
    input  valid_out,
    input  upd_pulse,
    input  upd_idx,
    input  err_pulse,
    input  err_cnt
  );

  modport slave (
    input  sel_in,
    input  seg_in,
    output digits_out,
    output valid_out,
    output upd_pulse,
    output upd_idx,
    output err_pulse,
    output err_cnt
  );
endinterface

// File: rtl/seg7_capture.sv
// Samples a time-multiplexed seven-segment bus, debounces each select/pattern
// window and decodes it back to a BCD value per digit, flagging bad windows.
module seg7_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  seg7_capture_if.slave bus
);

  localparam logic [7:0] CNT_MAX   = 8'(STABLE_CYCLES - 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    TRACK,
    DONE
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  logic [7:0]  sel_reg;
  logic [6:0]  seg_reg;
  logic [7:0]  cnt_reg;
  logic [7:0]  cnt_next;
  logic        same;
  logic        commit;

  logic [3:0]  dec_value;
  logic        dec_ok;
  logic        is_blank;
  logic        sel_nonzero;
  logic        sel_onehot;
  logic [2:0]  sel_idx;
  logic        commit_digit;
  logic        commit_err;

  logic        upd_pulse_reg;
  logic        err_pulse_reg;
  logic [2:0]  upd_idx_reg;
  logic [7:0]  err_cnt_reg;

  // Input stage: every decision downstream is taken from this sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_reg <= 8'h00;
      seg_reg <= SEG_BLANK;
    end else begin
      sel_reg <= bus.sel_in;
      seg_reg <= bus.seg_in;
    end
  end

  // The sample about to be taken equals the held one, so cnt_next describes
  // the window the register will hold after this edge.
  assign same = (bus.sel_in == sel_reg) && (bus.seg_in == seg_reg);

  always_comb begin
    cnt_next = 8'd0;
    if (!same) begin
      cnt_next = 8'd0;
    end else if (cnt_reg >= CNT_MAX) begin
      cnt_next = CNT_MAX;
    end else begin
      cnt_next = cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= 8'd0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= TRACK;
    end else begin
      state_reg <= state_next;
    end
  end

  // An idle bus (sel = 0) stays in TRACK so it never commits.
  always_comb begin
    state_next = state_reg;
    commit     = 1'b0;
    case (state_reg)
      TRACK: begin
        if (same && (cnt_next == CNT_MAX) && sel_nonzero) begin
          commit     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (!same) begin
          state_next = TRACK;
        end
      end
      default: begin
        state_next = TRACK;
      end
    endcase
  end

  always_comb begin
    dec_value = 4'd0;
    dec_ok    = 1'b1;
    case (seg_reg)
      7'b0000001: dec_value = 4'd0;
      7'b1001111: dec_value = 4'd1;
      7'b0010010: dec_value = 4'd2;
      7'b0000110: dec_value = 4'd3;
      7'b1001100: dec_value = 4'd4;
      7'b0100100: dec_value = 4'd5;
      7'b0100000: dec_value = 4'd6;
      7'b0001111: dec_value = 4'd7;
      7'b0000000: dec_value = 4'd8;
      7'b0000100: dec_value = 4'd9;
      default:    dec_ok    = 1'b0;
    endcase
  end

  assign is_blank    = (seg_reg == SEG_BLANK);
  assign sel_nonzero = (sel_reg != 8'h00);
  assign sel_onehot  = sel_nonzero && ((sel_reg & (sel_reg - 8'd1)) == 8'h00);

  always_comb begin
    sel_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sel_reg[i]) begin
        sel_idx = 3'(i);
      end
    end
  end

  assign commit_digit = commit && sel_onehot;
  assign commit_err   = commit && (!sel_onehot || (!dec_ok && !is_blank));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_pulse_reg <= 1'b0;
      err_pulse_reg <= 1'b0;
      upd_idx_reg   <= 3'd0;
      err_cnt_reg   <= 8'd0;
    end else begin
      upd_pulse_reg <= commit;
      err_pulse_reg <= commit_err;
      if (commit_digit) begin
        upd_idx_reg <= sel_idx;
      end
      if (commit_err && (err_cnt_reg != 8'hFF)) begin
        err_cnt_reg <= err_cnt_reg + 8'd1;
      end
    end
  end

  // One value/valid pair per digit slot; only the selected slot listens.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit
      logic [3:0] value_reg;
      logic       valid_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          value_reg <= 4'd0;
          valid_reg <= 1'b0;
        end else if (commit_digit && sel_reg[gi]) begin
          if (dec_ok) begin
            value_reg <= dec_value;
            valid_reg <= 1'b1;
          end else if (is_blank) begin
            valid_reg <= 1'b0;
          end
        end
      end

      assign bus.digits_out[4*gi +: 4] = value_reg;
      assign bus.valid_out[gi]         = valid_reg;
    end
  endgenerate

  assign bus.upd_pulse = upd_pulse_reg;
  assign bus.err_pulse = err_pulse_reg;
  assign bus.upd_idx   = upd_idx_reg;
  assign bus.err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: directed scenarios plus random runs
// compared against a window-level behavioural model of the capture rules.
module tb_seg7_capture;

  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_capture_if bus();

  seg7_capture #(.STABLE_CYCLES(STABLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Model: length of the current run of identical samples, whether that run
  // was already committed, and the architecturally visible results.
  logic [14:0] m_last;
  int          m_run;
  bit          m_done;
  logic [3:0]  m_digit [8];
  logic [7:0]  m_valid;
  logic [2:0]  m_upd_idx;
  int          m_err_cnt;
  bit          m_upd_pulse;
  bit          m_err_pulse;

  int dut_upd = 0;
  int dut_err = 0;
  int skew = 0;

  logic [6:0] pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  function automatic int lookup(input logic [6:0] s);
    for (int i = 0; i < 10; i++) begin
      if (pat[i] == s) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] exp_digits();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = m_digit[i];
    return r;
  endfunction

  task automatic model_reset();
    m_last      = {8'h00, 7'h7F};
    m_run       = 1;
    m_done      = 1'b0;
    for (int i = 0; i < 8; i++) m_digit[i] = 4'd0;
    m_valid     = 8'h00;
    m_upd_idx   = 3'd0;
    m_err_cnt   = 0;
    m_upd_pulse = 1'b0;
    m_err_pulse = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] sel, input logic [6:0] seg);
    int d;
    int idx;
    m_upd_pulse = 1'b0;
    m_err_pulse = 1'b0;
    if ({sel, seg} != m_last) begin
      m_last = {sel, seg};
      m_run  = 1;
      m_done = 1'b0;
    end else begin
      m_run++;
    end
    if (!m_done && m_run >= STABLE && sel != 8'h00) begin
      m_done      = 1'b1;
      m_upd_pulse = 1'b1;
      if ($countones(sel) != 1) begin
        m_err_pulse = 1'b1;
      end else begin
        idx = 0;
        for (int i = 0; i < 8; i++) if (sel[i]) idx = i;
        m_upd_idx = 3'(idx);
        d = lookup(seg);
        if (d >= 0) begin
          m_digit[idx] = 4'(d);
          m_valid[idx] = 1'b1;
        end else if (seg == 7'h7F) begin
          m_valid[idx] = 1'b0;
        end else begin
          m_err_pulse = 1'b1;
        end
      end
      if (m_err_pulse && m_err_cnt < 255) m_err_cnt++;
    end
  endtask

  // One sampled cycle: drive at the falling edge, let the DUT and model see
  // the same rising edge, observe strobes at the next falling edge.
  task automatic step(input logic [7:0] sel, input logic [6:0] seg);
    bus.sel_in = sel;
    bus.seg_in = seg;
    @(posedge clk);
    model_edge(sel, seg);
    @(negedge clk);
    if (bus.upd_pulse === 1'b1) dut_upd++;
    if (bus.err_pulse === 1'b1) dut_err++;
    if (bus.upd_pulse !== m_upd_pulse || bus.err_pulse !== m_err_pulse) skew++;
  endtask

  task automatic hold(input logic [7:0] sel, input logic [6:0] seg, input int n);
    for (int k = 0; k < n; k++) step(sel, seg);
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int u0;
    hold(8'h40, 7'b0000110, 5);
    hold(8'h40, 7'b1110000, 5);
    tests_run++;
    if (bus.err_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL reset_pre_errcnt: got %0d expected 1", bus.err_cnt);
    end
    tests_run++;
    if (bus.digits_out !== 32'h0300_0000) begin
      tests_failed++;
      $display("FAIL reset_pre_digits: got %h expected 03000000", bus.digits_out);
    end
    hold(8'h04, 7'b0100100, 3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (bus.digits_out !== 32'h0 || bus.valid_out !== 8'h00 || bus.upd_pulse !== 1'b0 ||
        bus.upd_idx !== 3'd0 || bus.err_pulse !== 1'b0 || bus.err_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_async: got digits=%h valid=%h upd=%b idx=%0d err=%b cnt=%0d expected all zero",
               bus.digits_out, bus.valid_out, bus.upd_pulse, bus.upd_idx, bus.err_pulse, bus.err_cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    u0 = dut_upd;
    hold(8'h04, 7'b0100100, 3);
    tests_run++;
    if (dut_upd != u0) begin
      tests_failed++;
      $display("FAIL reset_no_early_pulse: got %0d pulses expected 0", dut_upd - u0);
    end
    step(8'h04, 7'b0100100);
    tests_run++;
    if (bus.upd_pulse !== 1'b1 || bus.digits_out !== 32'h0000_0500) begin
      tests_failed++;
      $display("FAIL reset_new_window: got upd=%b digits=%h expected 1 00000500",
               bus.upd_pulse, bus.digits_out);
    end
  endtask

  task automatic test_good_digit();
    int u0;
    int s0;
    s0 = skew;
    for (int k = 0; k < 4; k++) begin
      step(8'h04, 7'b0010010);
      tests_run++;
      if (bus.upd_pulse !== ((k == 3) ? 1'b1 : 1'b0)) begin
        tests_failed++;
        $display("FAIL good_pulse_timing: step %0d got %b expected %b", k, bus.upd_pulse, (k == 3));
      end
    end
    tests_run++;
    if (bus.digits_out[11:8] !== 4'd2 || bus.valid_out !== 8'h04 || bus.upd_idx !== 3'd2) begin
      tests_failed++;
      $display("FAIL good_digit: got d=%0d valid=%h idx=%0d expected 2 04 2",
               bus.digits_out[11:8], bus.valid_out, bus.upd_idx);
    end
    u0 = dut_upd;
    hold(8'h04, 7'b0010010, 20);
    tests_run++;
    if (dut_upd != u0 || skew != s0) begin
      tests_failed++;
      $display("FAIL good_single_commit: got %0d extra pulses, %0d skew cycles expected 0 0",
               dut_upd - u0, skew - s0);
    end
  endtask

  task automatic test_scan_sweep();
    int vals [8] = '{7, 1, 9, 0, 3, 8, 5, 4};
    int u0;
    u0 = dut_upd;
    for (int i = 0; i < 8; i++) hold(8'(1 << i), pat[vals[i]], 6);
    tests_run++;
    if (bus.digits_out !== 32'h4583_0917 || bus.valid_out !== 8'hFF) begin
      tests_failed++;
      $display("FAIL sweep_digits: got %h/%h expected 45830917/ff", bus.digits_out, bus.valid_out);
    end
    tests_run++;
    if (dut_upd - u0 != 8) begin
      tests_failed++;
      $display("FAIL sweep_pulses: got %0d expected 8", dut_upd - u0);
    end
  endtask

  task automatic test_debounce();
    int u0;
    u0 = dut_upd;
    hold(8'h01, 7'b1001111, 3);
    step(8'h01, 7'b0000001);
    tests_run++;
    if (dut_upd != u0 || bus.digits_out[3:0] !== 4'd7) begin
      tests_failed++;
      $display("FAIL debounce_short: got %0d pulses d0=%0d expected 0 7", dut_upd - u0, bus.digits_out[3:0]);
    end
    hold(8'h01, 7'b1001111, 4);
    tests_run++;
    if (dut_upd - u0 != 1 || bus.digits_out[3:0] !== 4'd1) begin
      tests_failed++;
      $display("FAIL debounce_commit: got %0d pulses d0=%0d expected 1 1", dut_upd - u0, bus.digits_out[3:0]);
    end
  endtask

  task automatic test_blank_errors();
    int e0;
    e0 = dut_err;
    hold(8'h08, 7'h7F, 5);
    tests_run++;
    if (bus.valid_out !== 8'hF7 || bus.digits_out[15:12] !== 4'd0 || dut_err != e0 || bus.upd_idx !== 3'd3) begin
      tests_failed++;
      $display("FAIL blank: got valid=%h d3=%0d errs=%0d idx=%0d expected f7 0 0 3",
               bus.valid_out, bus.digits_out[15:12], dut_err - e0, bus.upd_idx);
    end
    hold(8'h08, 7'b1110000, 5);
    tests_run++;
    if (bus.err_cnt !== 8'd1 || dut_err - e0 != 1 || bus.digits_out !== 32'h4583_0911 || bus.valid_out !== 8'hF7) begin
      tests_failed++;
      $display("FAIL bad_pattern: got cnt=%0d digits=%h valid=%h expected 1 45830911 f7",
               bus.err_cnt, bus.digits_out, bus.valid_out);
    end
    hold(8'h11, 7'b0000001, 5);
    tests_run++;
    if (bus.err_cnt !== 8'd2 || bus.upd_idx !== 3'd3 || bus.digits_out !== exp_digits()) begin
      tests_failed++;
      $display("FAIL bad_select: got cnt=%0d idx=%0d digits=%h expected 2 3 %h",
               bus.err_cnt, bus.upd_idx, bus.digits_out, exp_digits());
    end
  endtask

  task automatic test_saturation_idle();
    int e0;
    int u0;
    e0 = dut_err;
    for (int w = 0; w < 300; w++) hold(8'h02, (w % 2 == 0) ? 7'b1110000 : 7'b1110001, 4);
    tests_run++;
    if (bus.err_cnt !== 8'd255 || dut_err - e0 != 300) begin
      tests_failed++;
      $display("FAIL err_saturate: got cnt=%0d pulses=%0d expected 255 300", bus.err_cnt, dut_err - e0);
    end
    u0 = dut_upd;
    e0 = dut_err;
    hold(8'h00, 7'b0000001, 50);
    tests_run++;
    if (dut_upd != u0 || dut_err != e0) begin
      tests_failed++;
      $display("FAIL idle: got upd=%0d err=%0d expected 0 0", dut_upd - u0, dut_err - e0);
    end
  endtask

  task automatic test_random();
    logic [7:0] sel;
    logic [6:0] seg;
    int kind;
    int s0;
    apply_reset();
    s0 = skew;
    for (int r = 0; r < 60; r++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 6) sel = 8'(1 << $urandom_range(0, 7));
      else if (kind == 7) sel = 8'h00;
      else sel = 8'(1 << $urandom_range(0, 3)) | 8'(1 << $urandom_range(4, 7));
      kind = $urandom_range(0, 9);
      if (kind <= 6) seg = pat[$urandom_range(0, 9)];
      else if (kind == 7) seg = 7'h7F;
      else seg = 7'($urandom);
      hold(sel, seg, $urandom_range(1, 7));
      tests_run++;
      if (bus.digits_out !== exp_digits() || bus.valid_out !== m_valid) begin
        tests_failed++;
        $display("FAIL random_digits: run %0d got %h/%h expected %h/%h",
                 r, bus.digits_out, bus.valid_out, exp_digits(), m_valid);
      end
      tests_run++;
      if (bus.upd_idx !== m_upd_idx || bus.err_cnt !== 8'(m_err_cnt)) begin
        tests_failed++;
        $display("FAIL random_status: run %0d got idx=%0d cnt=%0d expected %0d %0d",
                 r, bus.upd_idx, bus.err_cnt, m_upd_idx, m_err_cnt);
      end
    end
    tests_run++;
    if (skew != s0) begin
      tests_failed++;
      $display("FAIL random_pulses: got %0d mismatched strobe cycles expected 0", skew - s0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.sel_in = 8'h00;
    bus.seg_in = 7'h7F;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_good_digit();
    test_scan_sweep();
    test_debounce();
    test_blank_errors();
    test_saturation_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Receive-side companion to the display path: samples a time-multiplexed seven-segment bus (one-hot digit select plus 7-bit segment pattern), debounces each digit slot, and decodes the pattern back to a 4-bit BCD value per digit. It sits between the display pins and the debug and self-test logic, so the bench and on-chip checkers can read back what the display is actually showing.

## Interface
Parameters:
- STABLE_CYCLES, default 4: consecutive sampled cycles with an unchanged {sel_in, seg_in} required before a commit. Legal range 2..255.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- sel_in  input  8  digit select, active-high, expected one-hot; bit i selects digit i.
- seg_in  input  7  segment pattern, bit 6 = segment a … bit 0 = segment g, active-low.
- digits_out  output  32  digit i value in bits [4i+3:4i].
- valid_out  output  8  bit i set when digit i holds a decoded BCD value; clear when blank or never written.
- upd_pulse  output  1  one-cycle strobe on every commit, including error commits.
- upd_idx  output  3  digit index of the last commit. Held between commits.
- err_pulse  output  1  one-cycle strobe when a commit finds a bad pattern or a bad select.
- err_cnt  output  8  saturating count of err_pulse events.

## Operation
- Input stage: {sel_in, seg_in} is registered into smp every clk edge. All decisions use smp only.
- Stability counter cnt (8 bit):
  - Reset to 0 when smp differs from the previous smp.
  - Otherwise increments, saturating at STABLE_CYCLES-1.
- FSM states:
  - TRACK: counting stability.
  - DONE: the current window is already committed.
- FSM transitions:
  - TRACK -> DONE on the edge where cnt reaches STABLE_CYCLES-1 and sel is nonzero. The commit happens on this edge.
  - DONE -> TRACK on any smp change.
  - Staying in TRACK with sel = 0: the display is idle. No commit, no error, and cnt keeps counting.
- Commit, good case (sel one-hot with index i, pattern in the decode table):
  - digits_out[i] gets the decoded value and valid_out[i] is set.
  - upd_idx = i, upd_pulse = 1.
- Decode table (pattern -> value):
  - 0000001 -> 0, 1001111 -> 1, 0010010 -> 2, 0000110 -> 3, 1001100 -> 4.
  - 0100100 -> 5, 0100000 -> 6, 0001111 -> 7, 0000000 -> 8, 0000100 -> 9.
- Blank pattern 1111111:
  - valid_out[i] is cleared and digits_out[i] is unchanged.
  - upd_pulse = 1; not an error.
- Any other pattern:
  - digits_out[i] and valid_out[i] are unchanged.
  - upd_idx = i, upd_pulse = 1, err_pulse = 1, err_cnt increments.
- Select with more than one bit set:
  - No digit is written and upd_idx is unchanged.
  - upd_pulse = 1, err_pulse = 1, err_cnt increments.
- err_cnt saturates at 255 and does not wrap.
- Reset mid-operation aborts any window without a commit. All state returns to reset values immediately, without waiting for clk.

## Timing
- Reset values: digits_out = 0, valid_out = 0, upd_pulse = 0, upd_idx = 0, err_pulse = 0, err_cnt = 0, cnt = 0, FSM = TRACK, smp = {8'h00, 7'h7F}.
- Latency: if the input is stable before edge E0, the commit happens at edge E0+STABLE_CYCLES-1 (edge 3 for the default of 4).
  - digits_out, valid_out and upd_idx change at that edge.
  - upd_pulse and err_pulse are high for exactly the following cycle.
- A value held for any length of time commits exactly once. Re-commit requires a change followed by a new stable window.
- Changes of shorter duration than STABLE_CYCLES produce no commit. A glitch that returns to the previous value restarts the window and commits again once stable.
- rst_n release is asynchronous-assert, synchronous-deassert at the system level. The first sample is taken on the first edge after deassertion.
- Commits to the same digit in consecutive windows overwrite it; the last commit wins.

## Test plan
- Reset: assert rst_n = 0 mid-window with cnt = 2 -> all outputs at reset values at once; no upd_pulse after release until a new 4-cycle window completes.
- Good digit: sel_in = 8'h04, seg_in = 7'b0010010 held 4 cycles -> digits_out[11:8] = 2, valid_out = 8'h04, upd_idx = 2, and a single upd_pulse exactly 3 edges after the first sample. Holding the value 20 more cycles gives no further pulse.
- Scan sweep: drive digits 0..7 with values 7,1,9,0,3,8,5,4 for 6 cycles each -> digits_out = 32'h4583_0917, valid_out = 8'hFF, eight upd_pulses.
- Debounce: present sel_in = 8'h01 with 7'b1001111 for 3 cycles, then change -> no commit; hold 4 cycles -> digit 0 = 1.
- Blank and errors:
  - Blank 7'h7F on digit 3 -> valid_out[3] = 0 with digits_out[15:12] kept, no err_pulse.
  - Pattern 7'b1110000 -> err_pulse, err_cnt = 1, digit data untouched.
  - sel_in = 8'h11 -> err_pulse, err_cnt = 2, upd_idx unchanged.
- Saturation and idle: 300 bad-pattern windows -> err_cnt stops at 255. sel_in = 0 held 50 cycles -> no pulses.
